// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage pipeline with a multi-cycle MDU beside EX.
// Covers load-use and MDU RAW/WAW stalls, EX forwarding selects, the in-flight MDU scoreboard and redirect flushes.
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W      = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int PERF_CNT_W      = 32,
    localparam int NREG           = 2**REG_ADDR_W,
    localparam int OCC_W          = $clog2(MAX_OUTSTANDING+1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  rs1_used_id,
    input  logic                  rs2_used_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  reg_wr_id,
    input  logic                  mdu_op_id,
    input  logic [REG_ADDR_W-1:0] rs1_ex,
    input  logic [REG_ADDR_W-1:0] rs2_ex,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic                  reg_wr_ex,
    input  logic                  is_load_ex,
    input  logic [REG_ADDR_W-1:0] rd_mem,
    input  logic                  reg_wr_mem,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic                  reg_wr_wb,
    input  logic                  mdu_done,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic                  redirect_ex,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  flush_id,
    output logic                  bubble_ex,
    output logic                  mdu_issue,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [NREG-1:0]       sb_pending,
    output logic [OCC_W-1:0]      outstanding,
    output logic [PERF_CNT_W-1:0] stall_cycles
);

    logic src_hit1, src_hit2;
    logic load_use, sb_raw, sb_waw, sb_full, hazard;
    logic done_eff;
    logic [NREG-1:0] sb_next;

    assign src_hit1 = id_valid & rs1_used_id & (rs1_id != '0);
    assign src_hit2 = id_valid & rs2_used_id & (rs2_id != '0);

    assign load_use = is_load_ex & reg_wr_ex &
                      ((src_hit1 & (rs1_id == rd_ex)) | (src_hit2 & (rs2_id == rd_ex)));

    // A completing MDU op is forwarded through WB, so its register is no longer a hazard
    assign sb_raw = (src_hit1 & sb_pending[rs1_id] & ~(mdu_done & (mdu_rd == rs1_id))) |
                    (src_hit2 & sb_pending[rs2_id] & ~(mdu_done & (mdu_rd == rs2_id)));

    assign sb_waw = id_valid & reg_wr_id & (rd_id != '0) & sb_pending[rd_id] &
                    ~(mdu_done & (mdu_rd == rd_id));

    assign sb_full = id_valid & mdu_op_id & (outstanding == OCC_W'(MAX_OUTSTANDING)) & ~mdu_done;

    assign hazard = load_use | sb_raw | sb_waw | sb_full;

    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        if (redirect_ex) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
        end else if (hazard) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
        end
    end

    assign mdu_issue = id_valid & mdu_op_id & ~hazard & ~redirect_ex;

    assign fwd_a_sel = (rs1_ex == '0)                   ? 2'd0 :
                       (reg_wr_mem && rd_mem == rs1_ex) ? 2'd1 :
                       (reg_wr_wb  && rd_wb  == rs1_ex) ? 2'd2 : 2'd0;
    assign fwd_b_sel = (rs2_ex == '0)                   ? 2'd0 :
                       (reg_wr_mem && rd_mem == rs2_ex) ? 2'd1 :
                       (reg_wr_wb  && rd_wb  == rs2_ex) ? 2'd2 : 2'd0;

    // Clear before set so a register retiring and re-issuing in one cycle stays pending
    always_comb begin
        sb_next = sb_pending;
        if (mdu_done)
            sb_next[mdu_rd] = 1'b0;
        if (mdu_issue && rd_id != '0)
            sb_next[rd_id] = 1'b1;
    end

    assign done_eff = mdu_done & (outstanding != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sb_pending   <= '0;
            outstanding  <= '0;
            stall_cycles <= '0;
        end else begin
            sb_pending <= sb_next;
            if (mdu_issue && !done_eff)
                outstanding <= outstanding + OCC_W'(1);
            else if (done_eff && !mdu_issue)
                outstanding <= outstanding - OCC_W'(1);
            if (stall_id && stall_cycles != '1)
                stall_cycles <= stall_cycles + PERF_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit; a 3-bit stall counter makes saturation reachable.
module tb_hazard_scoreboard_unit;

    localparam int RW  = 5;
    localparam int MO  = 4;
    localparam int PCW = 3;

    logic clk = 1'b0;
    logic reset_n;
    logic id_valid, rs1_used_id, rs2_used_id, reg_wr_id, mdu_op_id;
    logic [RW-1:0] rs1_id, rs2_id, rd_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb, mdu_rd;
    logic reg_wr_ex, is_load_ex, reg_wr_mem, reg_wr_wb, mdu_done, redirect_ex;
    logic stall_if, stall_id, flush_id, bubble_ex, mdu_issue;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [31:0] sb_pending;
    logic [2:0] outstanding;
    logic [PCW-1:0] stall_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.REG_ADDR_W(RW), .MAX_OUTSTANDING(MO), .PERF_CNT_W(PCW)) dut (
        .clk(clk), .reset_n(reset_n),
        .id_valid(id_valid), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .rd_id(rd_id), .reg_wr_id(reg_wr_id), .mdu_op_id(mdu_op_id),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
        .reg_wr_ex(reg_wr_ex), .is_load_ex(is_load_ex),
        .rd_mem(rd_mem), .reg_wr_mem(reg_wr_mem), .rd_wb(rd_wb), .reg_wr_wb(reg_wr_wb),
        .mdu_done(mdu_done), .mdu_rd(mdu_rd), .redirect_ex(redirect_ex),
        .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
        .bubble_ex(bubble_ex), .mdu_issue(mdu_issue),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .sb_pending(sb_pending), .outstanding(outstanding), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; rs1_used_id = 0; rs2_used_id = 0; reg_wr_id = 0; mdu_op_id = 0;
        rs1_id = 0; rs2_id = 0; rd_id = 0; rs1_ex = 0; rs2_ex = 0; rd_ex = 0;
        rd_mem = 0; rd_wb = 0; mdu_rd = 0;
        reg_wr_ex = 0; is_load_ex = 0; reg_wr_mem = 0; reg_wr_wb = 0;
        mdu_done = 0; redirect_ex = 0;
    endtask

    // inputs change 1 time unit after the rising edge, checks 1 unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mdu_op(input logic [RW-1:0] rd);
        id_valid = 1; mdu_op_id = 1; reg_wr_id = 1; rd_id = rd;
    endtask

    initial begin
        idle();
        reset_n = 0;
        #12;
        chk("rst_pending", sb_pending, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        chk("rst_stall_id", stall_id, 0);
        reset_n = 1;
        step();

        // load-use on rs1
        is_load_ex = 1; reg_wr_ex = 1; rd_ex = 5;
        id_valid = 1; rs1_id = 5; rs1_used_id = 1; reg_wr_id = 1; rd_id = 6;
        #1;
        chk("lu_stall_if", stall_if, 1);
        chk("lu_stall_id", stall_id, 1);
        chk("lu_bubble", bubble_ex, 1);
        chk("lu_flush", flush_id, 0);
        step();
        is_load_ex = 0;
        #1;
        chk("lu_released", stall_id, 0);
        chk("lu_stall_cycles", stall_cycles, 1);
        is_load_ex = 1; rs1_used_id = 0;
        #1;
        chk("lu_unused_src", stall_id, 0);
        step();
        chk("lu_unused_cnt", stall_cycles, 1);

        // redirect dominates a load-use hazard and blocks MDU issue
        rs1_used_id = 1; redirect_ex = 1; mdu_op_id = 1;
        #1;
        chk("rd_flush", flush_id, 1);
        chk("rd_bubble", bubble_ex, 1);
        chk("rd_stall_if", stall_if, 0);
        chk("rd_stall_id", stall_id, 0);
        chk("rd_issue", mdu_issue, 0);
        step();
        chk("rd_cnt", stall_cycles, 1);
        idle();

        // MDU RAW on x7
        mdu_op(7);
        #1;
        chk("raw_issue", mdu_issue, 1);
        step();
        idle();
        id_valid = 1; rs1_id = 7; rs1_used_id = 1; reg_wr_id = 1; rd_id = 8;
        #1;
        chk("raw_pending7", sb_pending[7], 1);
        chk("raw_outst1", outstanding, 1);
        chk("raw_stall", stall_id, 1);
        step();
        chk("raw_stall2", stall_id, 1);
        step();
        mdu_done = 1; mdu_rd = 7;
        #1;
        chk("raw_done_bypass", stall_id, 0);
        step();
        mdu_done = 0;
        #1;
        chk("raw_cleared", sb_pending, 0);
        chk("raw_outst0", outstanding, 0);
        chk("raw_cnt", stall_cycles, 3);
        idle();

        // fill the MDU to capacity with x1..x4
        for (int i = 1; i <= 4; i++) begin
            mdu_op(RW'(i));
            step();
        end
        chk("occ_outst4", outstanding, 4);
        chk("occ_pending", sb_pending, 32'h1E);
        mdu_op(5);
        #1;
        chk("occ_full_stall", stall_id, 1);
        chk("occ_full_issue", mdu_issue, 0);
        mdu_done = 1; mdu_rd = 1;
        #1;
        chk("occ_done_issue", mdu_issue, 1);
        chk("occ_done_stall", stall_id, 0);
        step();
        idle();
        chk("occ_outst_kept", outstanding, 4);
        chk("occ_pending2", sb_pending, 32'h3C);

        // WAW on pending x3, relieved by its completion
        id_valid = 1; reg_wr_id = 1; rd_id = 3;
        #1;
        chk("waw_stall", stall_id, 1);
        mdu_done = 1; mdu_rd = 3;
        #1;
        chk("waw_bypass", stall_id, 0);
        idle();

        // retire and re-issue the same register in one cycle
        mdu_op(9); mdu_done = 1; mdu_rd = 9;
        #1;
        chk("sim_issue", mdu_issue, 1);
        step();
        idle();
        chk("sim_pending9", sb_pending, 32'h23C);
        chk("sim_outst", outstanding, 4);
        mdu_done = 1; mdu_rd = 2;
        step();
        idle();
        chk("ret_outst3", outstanding, 3);
        mdu_op(0);
        step();
        idle();
        chk("rd0_pending", sb_pending, 32'h238);
        chk("rd0_outst4", outstanding, 4);

        // forwarding priority
        reg_wr_mem = 1; rd_mem = 3; reg_wr_wb = 1; rd_wb = 3; rs1_ex = 3; rs2_ex = 0;
        #1;
        chk("fwd_a_mem", fwd_a_sel, 1);
        chk("fwd_b_x0", fwd_b_sel, 0);
        rs2_ex = 4; rd_wb = 4;
        #1;
        chk("fwd_b_wb", fwd_b_sel, 2);
        rs1_ex = 0; rd_mem = 0;
        #1;
        chk("fwd_a_x0", fwd_a_sel, 0);
        rs1_ex = 6;
        #1;
        chk("fwd_a_none", fwd_a_sel, 0);
        idle();

        // stall counter saturation at 7
        is_load_ex = 1; reg_wr_ex = 1; rd_ex = 12;
        id_valid = 1; rs2_id = 12; rs2_used_id = 1;
        for (int i = 0; i < 6; i++) step();
        chk("sat_cnt", stall_cycles, 7);
        idle();

        // async reset mid-cycle
        #2;
        reset_n = 0;
        #1;
        chk("arst_pending", sb_pending, 0);
        chk("arst_outst", outstanding, 0);
        chk("arst_cnt", stall_cycles, 0);
        step();
        reset_n = 1;
        mdu_done = 1; mdu_rd = 4;
        step();
        idle();
        chk("done_at_zero", outstanding, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected finish before 20000");
        $fatal(1);
    end

endmodule
